// File: rtl/display_scan_mux_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_scan_mux_if
// Digit bus between the timekeeping logic and the display scanner.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface display_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    blank;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_start;

  // Scanner side: consumes the digit bus and drives the display
  modport slave (
    input  digits_in,
    input  blank,
    output bcd_out,
    output digit_en,
    output frame_start
  );

  // Producer side: supplies digits and observes the scan
  modport master (
    output digits_in,
    output blank,
    input  bcd_out,
    input  digit_en,
    input  frame_start
  );
endinterface
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_scan_mux
// Time-multiplexed 7-segment digit scanner with per-frame snapshot and
// anti-ghosting dead time at the start of every digit slot.
// Optional macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
// Revision: 1.0
// ---------------------------------------------------------------------------
module display_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter int DEAD       = 2
) (
  input logic               clk,
  input logic               reset_n,
  display_scan_mux_if.slave bus
);

  localparam int               CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int               IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow;

  logic                    tick;
  logic                    frame_wrap;
  logic                    sel_live;
  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [NUM_DIGITS-1:0]   suppress;

  assign tick       = (cnt == CNT_LAST);
  assign frame_wrap = tick && (idx == IDX_LAST);
  // Selects stay off during the dead window at the head of each slot
  assign sel_live   = (int'(cnt) >= DEAD) && !bus.blank;

  // Pick the current shadow digit and the matching one-hot select
  always_comb begin
    cur_digit  = 4'd0;
    sel_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit     = shadow[4*k +: 4];
        sel_onehot[k] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;

  // A digit is suppressed while it and everything above it are zero;
  // digit 0 always lights so a zero value still shows "0"
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run    = zero_run && (shadow[4*k +: 4] == 4'd0);
      suppress[k] = zero_run;
    end
  end
`else
  assign suppress = '0;
`endif

  // Prescaler, digit index and once-per-frame snapshot of the input bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      // Loading on the wrap tick means slot 0 already sees the new frame
      if (frame_wrap) begin
        shadow <= bus.digits_in;
      end
    end
  end

  // Registered outputs, one cycle behind the scan state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.bcd_out     <= 4'd0;
      bus.digit_en    <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.bcd_out     <= cur_digit;
      bus.digit_en    <= sel_live ? (sel_onehot & ~suppress) : '0;
      bus.frame_start <= frame_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_display_scan_mux
// Directed bench for display_scan_mux with PRESCALE=4, DEAD=1, NUM_DIGITS=4.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_display_scan_mux;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   total  = 0;
  int   passed = 0;

  display_scan_mux_if #(.NUM_DIGITS(4)) bus ();

  display_scan_mux #(
    .NUM_DIGITS(4),
    .PRESCALE  (4),
    .DEAD      (1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence never completes
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle at the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks one 16-cycle frame whose snapshot is val; lit is the set of
  // digits allowed to light. Optionally changes digits_in after cycle chg_i
  // and blanks cycles blk_i+1 .. blk_i+blk_n.
  task automatic run_frame(input logic [15:0] val, input logic [3:0] lit,
                           input int chg_i, input logic [15:0] chg_val,
                           input int blk_i, input int blk_n);
    logic [3:0] exp_en;
    int s;
    int c;
    for (int i = 0; i < 16; i++) begin
      step();
      s = i / 4;
      c = i % 4;
      if (c == 0 || (i > blk_i && i <= blk_i + blk_n))
        exp_en = 4'b0000;
      else
        exp_en = (4'b0001 << s) & lit;
      check("bcd_out", {12'd0, bus.bcd_out}, {12'd0, val[4*s +: 4]});
      check("digit_en", {12'd0, bus.digit_en}, {12'd0, exp_en});
      check("frame_start", {15'd0, bus.frame_start}, {15'd0, (i == 15)});
      if (i == chg_i) bus.digits_in = chg_val;
      if (i == blk_i) bus.blank = 1'b1;
      if (i == blk_i + blk_n) bus.blank = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] mask_zero;
    mask_zero = LZB ? 4'b0001 : 4'b1111;

    // Reset with random input
    reset_n       = 1'b0;
    bus.blank     = 1'b0;
    bus.digits_in = 16'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bcd_out", {12'd0, bus.bcd_out}, 16'h0000);
    check("rst_digit_en", {12'd0, bus.digit_en}, 16'h0000);
    check("rst_frame_start", {15'd0, bus.frame_start}, 16'h0000);

    // First frame after reset shows zeros; 1234 is captured at its end
    bus.digits_in = 16'h1234;
    reset_n = 1'b1;
    run_frame(16'h0000, mask_zero, -1, 16'h0000, -1, 0);

    // Scan order 4,3,2,1; input changes mid-frame must not tear
    run_frame(16'h1234, 4'b1111, 0, 16'h0959, -1, 0);

    // 0959 frame; switch to 1000 during slot 1, frame must stay intact
    run_frame(16'h0959, LZB ? 4'b0111 : 4'b1111, 5, 16'h1000, -1, 0);

    // Inner zeros are not leading zeros
    run_frame(16'h1000, 4'b1111, 0, 16'h1234, -1, 0);

    // Blank for 10 cycles mid-frame; scan phase continues underneath
    run_frame(16'h1234, 4'b1111, 0, 16'h00F0, 4, 10);

    // Out-of-range nibble passes through; also confirms phase after blank
    run_frame(16'h00F0, LZB ? 4'b0011 : 4'b1111, 0, 16'h0005, -1, 0);

    run_frame(16'h0005, LZB ? 4'b0001 : 4'b1111, 0, 16'h0000, -1, 0);

    run_frame(16'h0000, mask_zero, 0, 16'h5678, -1, 0);

    // Into slot 2 of the 5678 frame, then abort with an async reset
    repeat (10) step();
    check("pre_rst_bcd_out", {12'd0, bus.bcd_out}, 16'h0006);
    check("pre_rst_digit_en", {12'd0, bus.digit_en}, 16'h0004);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_bcd_out", {12'd0, bus.bcd_out}, 16'h0000);
    check("async_rst_digit_en", {12'd0, bus.digit_en}, 16'h0000);
    check("async_rst_frame_start", {15'd0, bus.frame_start}, 16'h0000);
    bus.digits_in = 16'h4321;
    #1;
    reset_n = 1'b1;

    // Restart from digit 0 with a cleared snapshot, then the new value
    run_frame(16'h0000, mask_zero, -1, 16'h0000, -1, 0);
    run_frame(16'h4321, 4'b1111, -1, 16'h0000, -1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
Time-multiplexed scanner that feeds the 7-segment BCD decoder stage of the alarm clock.
- Takes a packed bus of BCD digits from the timekeeping/alarm logic.
- Presents one digit at a time on `bcd_out` and drives a one-hot common-select `digit_en`.
- Snapshots the input once per frame so a rollover never tears mid-scan.
- Inserts anti-ghosting dead time at every digit change.

Parameters:
- NUM_DIGITS, 4, number of scanned digits (2..8); digit 0 is least significant.
- PRESCALE, 1000, clk cycles per digit slot (>= 2).
- DEAD, 2, cycles at the start of each slot with all selects off (0 <= DEAD < PRESCALE).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- digits_in  in  4*NUM_DIGITS  packed BCD; digit k = digits_in[4k+3:4k].
- blank  in  1  level; 1 forces all selects off.
- bcd_out  out  4  BCD nibble to the decoder.
- digit_en  out  NUM_DIGITS  one-hot active-high digit select.
- frame_start  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (reset_n=0, immediate, asynchronous):
  - Outputs: bcd_out=0, digit_en=0, frame_start=0.
  - Internal state: prescale count cnt=0, digit index idx=0, shadow snapshot register=0.
  - Asserting reset mid-frame aborts the scan. After release, scanning restarts at idx 0, cnt 0 on the first clk edge.
- Prescaler: cnt counts 0..PRESCALE-1 and wraps. tick = (cnt==PRESCALE-1).
- Digit index:
  - On tick, idx increments.
  - idx==NUM_DIGITS-1 wraps to 0.
- Snapshot:
  - On tick with idx==NUM_DIGITS-1, shadow <= digits_in.
  - frame_start is registered high for exactly that one following cycle.
  - Changes on digits_in at any other time are not visible until the next snapshot.
  - The first frame after reset displays zeros.
- Output registers, updated every cycle from current state (1-cycle latency):
  - bcd_out <= shadow digit[idx].
  - digit_en <= onehot(idx) if cnt >= DEAD, blank==0 and the digit is not suppressed; otherwise all zero.
  - bcd_out keeps scanning while blanked.
- Each digit is therefore enabled for PRESCALE-DEAD cycles per slot. At most one digit_en bit is high in any cycle.
- blank: sampled every cycle, affects digit_en on the next edge. Scan position is unaffected, so there is no phase jump when blank drops.
- Values 10..15 in a digit are passed through unmodified; the decoder shows them as a dash.
- Simultaneous events: a tick on the wrap slot both loads the snapshot and moves idx to 0. bcd_out for slot 0 therefore uses the new snapshot.

Optional Feature:
Macro: LEADING_ZERO_BLANK_EN.
- Defined: a digit k>0 is suppressed (digit_en forced 0) when it and every more-significant digit in the shadow are 0. Digit 0 is never suppressed.
  - Example: shadow 0,0,0,5 (MSD first) lights only digit 0.
  - Example: 0,1,0,7 lights digits 2, 1 and 0.
- Not defined: no suppression; all digits light per the normal rules.
- Timing is identical either way.

Test Plan:
All scenarios use PRESCALE=4, DEAD=1, NUM_DIGITS=4.
1. Reset: hold reset_n=0 with random digits_in, toggle clk -> bcd_out=0, digit_en=0000, frame_start=0. Pulse reset_n low mid-slot 2 -> outputs clear immediately and scan restarts at digit 0.
2. Scan order: digits_in=16'h1234 after reset -> first frame shows bcd_out=0. After the first frame_start, the per-slot sequence is bcd_out 4,3,2,1 with digit_en 0001,0010,0100,1000. Each select is high for 3 cycles after 1 dead cycle; the frame period is 16 cycles.
3. Tear-free snapshot: change digits_in from 16'h0959 to 16'h1000 during slot 1 -> the rest of the frame still shows 9,5,9 digits. The new value appears only after the next frame_start.
4. Blank: assert blank for 10 cycles mid-frame -> digit_en=0000 from the next cycle. On release, scanning resumes at the correct phase with no idx reset.
5. Invalid digit: digits_in=16'h00F0 -> bcd_out=4'hF during slot 1, passed through unchanged.
6. With LEADING_ZERO_BLANK_EN defined: digits_in=16'h0005 -> only digit_en=0001 ever asserts. digits_in=16'h0000 -> only digit 0 lights, showing 0.
